axi_to_apb_wrap: RTL and testbench

AXI_TO_APB_WRAP -- requirements
Module: axi_to_apb_wrap

---
 rtl/axi_to_apb_wrap_if.sv | 96 +++++++++
 rtl/axi_to_apb_wrap.sv | 168 ++++++++++++++++
 tb/tb_axi_to_apb_wrap.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_to_apb_wrap_if.sv
// AXI4 and APB3 bus bundles used by the AXI-to-APB bridge.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

interface APB_BUS #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/axi_to_apb_wrap.sv
// AXI4 slave to APB3 master bridge; one AXI transaction at a time, one APB
// transfer per AXI beat. Write strobes and wlast are ignored.
module axi_to_apb_wrap #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned APB_ADDR_WIDTH = 32
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   test_en_i,
    AXI_BUS.slave  axi_slave,
    APB_BUS.master apb_master
);

    typedef enum logic [2:0] {
        IDLE,
        W_DATA,
        SETUP,
        ACCESS,
        B_RESP,
        R_RESP
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_e                    state_q, state_d;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;
    logic [7:0]                len_q;
    logic [1:0]                burst_q;
    logic [7:0]                beat_q;
    logic [AXI_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic                      err_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                      rerr_q;
    logic                      last_beat;

    // test_en_i and the ignored AXI side-band fields have no functional use
    logic unused_inputs;
    assign unused_inputs = ^{test_en_i, axi_slave.w_strb, axi_slave.w_last,
                             axi_slave.w_user, axi_slave.aw_size, axi_slave.ar_size,
                             axi_slave.aw_user, axi_slave.ar_user};

    assign last_beat = (beat_q == len_q);
    // WRAP bursts advance like INCR; FIXED keeps the address
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + AXI_ADDR_WIDTH'(4);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; AW has priority over AR in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (axi_slave.aw_valid)      state_d = W_DATA;
                else if (axi_slave.ar_valid) state_d = SETUP;
            end
            W_DATA: if (axi_slave.w_valid) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (apb_master.pready) begin
                    if (pwrite_q) state_d = last_beat ? B_RESP : W_DATA;
                    else          state_d = R_RESP;
                end
            end
            B_RESP: if (axi_slave.b_ready) state_d = IDLE;
            R_RESP: if (axi_slave.r_ready) state_d = last_beat ? IDLE : SETUP;
            default: state_d = IDLE;
        endcase
    end

    // Transaction fields, beat counter, APB data and response capture
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (axi_slave.aw_valid) begin
                        id_q    <= axi_slave.aw_id;
                        addr_q  <= axi_slave.aw_addr;
                        len_q   <= axi_slave.aw_len;
                        burst_q <= axi_slave.aw_burst;
                        beat_q  <= '0;
                    end else if (axi_slave.ar_valid) begin
                        id_q     <= axi_slave.ar_id;
                        addr_q   <= axi_slave.ar_addr;
                        len_q    <= axi_slave.ar_len;
                        burst_q  <= axi_slave.ar_burst;
                        beat_q   <= '0;
                        pwrite_q <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (axi_slave.w_valid) begin
                        pwdata_q <= axi_slave.w_data;
                        pwrite_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (apb_master.pready) begin
                        if (pwrite_q) begin
                            if (apb_master.pslverr) err_q <= 1'b1;
                            if (!last_beat) begin
                                beat_q <= beat_q + 8'd1;
                                addr_q <= addr_next;
                            end
                        end else begin
                            rdata_q <= apb_master.prdata;
                            rerr_q  <= apb_master.pslverr;
                        end
                    end
                end
                B_RESP: if (axi_slave.b_ready) err_q <= 1'b0;
                R_RESP: begin
                    if (axi_slave.r_ready && !last_beat) begin
                        beat_q <= beat_q + 8'd1;
                        addr_q <= addr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and bus outputs decoded from the current state
    always_comb begin
        axi_slave.aw_ready = rst_ni && (state_q == IDLE) && axi_slave.aw_valid;
        axi_slave.ar_ready = rst_ni && (state_q == IDLE) && !axi_slave.aw_valid
                             && axi_slave.ar_valid;
        axi_slave.w_ready  = (state_q == W_DATA);
        axi_slave.b_valid  = (state_q == B_RESP);
        axi_slave.b_id     = id_q;
        axi_slave.b_resp   = err_q ? RESP_SLVERR : RESP_OKAY;
        axi_slave.b_user   = '0;
        axi_slave.r_valid  = (state_q == R_RESP);
        axi_slave.r_id     = id_q;
        axi_slave.r_data   = rdata_q;
        axi_slave.r_resp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
        axi_slave.r_last   = last_beat;
        axi_slave.r_user   = '0;
        apb_master.psel    = (state_q == SETUP) || (state_q == ACCESS);
        apb_master.penable = (state_q == ACCESS);
        apb_master.paddr   = APB_ADDR_WIDTH'(addr_q);
        apb_master.pwdata  = pwdata_q;
        apb_master.pwrite  = pwrite_q;
    end

endmodule

// File: tb/tb_axi_to_apb_wrap.sv
// Directed bench for axi_to_apb_wrap: inputs driven and outputs checked on
// the falling clock edge.
module tb_axi_to_apb_wrap;

    logic clk;
    logic rst_ni;
    logic test_en_i;
    int   total = 0;
    int   bad   = 0;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(6),
              .AXI_USER_WIDTH(1)) axi ();
    APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();

    axi_to_apb_wrap #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(6),
        .AXI_USER_WIDTH(1),
        .APB_ADDR_WIDTH(32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .test_en_i  (test_en_i),
        .axi_slave  (axi),
        .apb_master (apb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_ni = 1'b0; test_en_i = 1'b0;
        axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = 3'd2;
        axi.aw_burst = 2'b01; axi.aw_user = '0; axi.aw_valid = 1'b0;
        axi.w_data = '0; axi.w_strb = 4'hF; axi.w_last = 1'b0; axi.w_user = '0;
        axi.w_valid = 1'b0; axi.b_ready = 1'b0;
        axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = 3'd2;
        axi.ar_burst = 2'b01; axi.ar_user = '0; axi.ar_valid = 1'b0;
        axi.r_ready = 1'b0;
        apb.prdata = '0; apb.pready = 1'b0; apb.pslverr = 1'b0;

        // ---- reset state ----
        tick(); tick();
        axi.aw_valid = 1'b1;
        tick();
        chk("rst_aw_ready", axi.aw_ready, 0);
        chk("rst_psel", apb.psel, 0);
        chk("rst_penable", apb.penable, 0);
        chk("rst_pwrite", apb.pwrite, 0);
        chk("rst_paddr", apb.paddr, 0);
        chk("rst_pwdata", apb.pwdata, 0);
        chk("rst_b_valid", axi.b_valid, 0);
        chk("rst_r_valid", axi.r_valid, 0);
        axi.aw_valid = 1'b0;
        rst_ni = 1'b1;
        tick();

        // ---- single write ----
        axi.aw_valid = 1'b1; axi.aw_addr = 32'h4000_0000; axi.aw_id = 6'd5;
        axi.aw_len = 8'd0; axi.aw_burst = 2'b01;
        #1;
        chk("w1_aw_ready", axi.aw_ready, 1);
        chk("w1_w_ready_idle", axi.w_ready, 0);
        tick();
        axi.aw_valid = 1'b0;
        #1;
        chk("w1_aw_ready_off", axi.aw_ready, 0);
        chk("w1_w_ready", axi.w_ready, 1);
        chk("w1_psel_wdata", apb.psel, 0);
        axi.w_valid = 1'b1; axi.w_data = 32'hDEAD_BEEF; apb.pready = 1'b1;
        tick();
        axi.w_valid = 1'b0;
        chk("w1_setup_psel", apb.psel, 1);
        chk("w1_setup_penable", apb.penable, 0);
        chk("w1_setup_paddr", apb.paddr, 32'h4000_0000);
        chk("w1_setup_pwrite", apb.pwrite, 1);
        chk("w1_setup_pwdata", apb.pwdata, 32'hDEAD_BEEF);
        tick();
        chk("w1_access_psel", apb.psel, 1);
        chk("w1_access_penable", apb.penable, 1);
        chk("w1_access_paddr", apb.paddr, 32'h4000_0000);
        chk("w1_access_pwdata", apb.pwdata, 32'hDEAD_BEEF);
        tick();
        chk("w1_b_valid", axi.b_valid, 1);
        chk("w1_b_id", axi.b_id, 5);
        chk("w1_b_resp", axi.b_resp, 2'b00);
        chk("w1_b_user", axi.b_user, 0);
        chk("w1_b_psel", apb.psel, 0);
        axi.b_ready = 1'b1;
        tick();
        axi.b_ready = 1'b0;
        chk("w1_b_done", axi.b_valid, 0);

        // ---- single read with wait states ----
        apb.pready = 1'b0;
        axi.ar_valid = 1'b1; axi.ar_addr = 32'h4000_0004; axi.ar_id = 6'd9;
        axi.ar_len = 8'd0; axi.ar_burst = 2'b01;
        #1;
        chk("r1_ar_ready", axi.ar_ready, 1);
        tick();
        axi.ar_valid = 1'b0;
        chk("r1_setup_psel", apb.psel, 1);
        chk("r1_setup_penable", apb.penable, 0);
        chk("r1_setup_pwrite", apb.pwrite, 0);
        chk("r1_setup_paddr", apb.paddr, 32'h4000_0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r1_wait_psel", apb.psel, 1);
            chk("r1_wait_penable", apb.penable, 1);
            chk("r1_wait_r_valid", axi.r_valid, 0);
        end
        tick();
        chk("r1_final_penable", apb.penable, 1);
        apb.pready = 1'b1; apb.prdata = 32'h1234_5678;
        tick();
        apb.prdata = 32'hFFFF_FFFF;
        chk("r1_r_valid", axi.r_valid, 1);
        chk("r1_r_data", axi.r_data, 32'h1234_5678);
        chk("r1_r_resp", axi.r_resp, 2'b00);
        chk("r1_r_last", axi.r_last, 1);
        chk("r1_r_id", axi.r_id, 9);
        chk("r1_r_user", axi.r_user, 0);
        chk("r1_r_psel", apb.psel, 0);
        axi.r_ready = 1'b1;
        tick();
        axi.r_ready = 1'b0;
        chk("r1_r_done", axi.r_valid, 0);

        // ---- INCR read burst, len 3, with an r_ready stall on beat 1 ----
        axi.ar_valid = 1'b1; axi.ar_addr = 32'h4000_0000; axi.ar_id = 6'd3;
        axi.ar_len = 8'd3; axi.ar_burst = 2'b01;
        #1;
        chk("rb_ar_ready", axi.ar_ready, 1);
        tick();
        axi.ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rb_setup_psel", apb.psel, 1);
            chk("rb_setup_penable", apb.penable, 0);
            chk("rb_paddr", apb.paddr, 32'h4000_0000 + 32'(4 * i));
            apb.prdata = 32'hA000_0000 + 32'(i);
            tick();
            chk("rb_access_penable", apb.penable, 1);
            tick();
            apb.prdata = 32'h0;
            chk("rb_r_valid", axi.r_valid, 1);
            chk("rb_r_data", axi.r_data, 32'hA000_0000 + 32'(i));
            chk("rb_r_last", axi.r_last, (i == 3) ? 1 : 0);
            chk("rb_r_id", axi.r_id, 3);
            if (i == 1) begin
                tick();
                chk("rb_stall_r_valid", axi.r_valid, 1);
                chk("rb_stall_r_data", axi.r_data, 32'hA000_0001);
                chk("rb_stall_psel", apb.psel, 0);
            end
            axi.r_ready = 1'b1;
            tick();
            axi.r_ready = 1'b0;
        end
        chk("rb_done_r_valid", axi.r_valid, 0);
        chk("rb_done_psel", apb.psel, 0);

        // ---- write burst len 1 with pslverr on first beat ----
        axi.aw_valid = 1'b1; axi.aw_addr = 32'h4000_0010; axi.aw_id = 6'd7;
        axi.aw_len = 8'd1; axi.aw_burst = 2'b01;
        tick();
        axi.aw_valid = 1'b0;
        axi.w_valid = 1'b1; axi.w_data = 32'h1111_1111;
        apb.pready = 1'b1; apb.pslverr = 1'b1;
        tick();
        axi.w_valid = 1'b0;
        chk("we_b0_paddr", apb.paddr, 32'h4000_0010);
        chk("we_b0_pwdata", apb.pwdata, 32'h1111_1111);
        tick();
        chk("we_b0_penable", apb.penable, 1);
        tick();
        apb.pslverr = 1'b0;
        chk("we_mid_w_ready", axi.w_ready, 1);
        chk("we_mid_b_valid", axi.b_valid, 0);
        axi.w_valid = 1'b1; axi.w_data = 32'h2222_2222;
        tick();
        axi.w_valid = 1'b0;
        chk("we_b1_psel", apb.psel, 1);
        chk("we_b1_paddr", apb.paddr, 32'h4000_0014);
        chk("we_b1_pwdata", apb.pwdata, 32'h2222_2222);
        tick();
        chk("we_b1_penable", apb.penable, 1);
        tick();
        chk("we_b_valid", axi.b_valid, 1);
        chk("we_b_resp", axi.b_resp, 2'b10);
        chk("we_b_id", axi.b_id, 7);
        axi.b_ready = 1'b1;
        tick();
        axi.b_ready = 1'b0;
        chk("we_b_done", axi.b_valid, 0);

        // ---- AW and AR together: write first, then read ----
        axi.aw_valid = 1'b1; axi.aw_addr = 32'h4000_0020; axi.aw_id = 6'd1;
        axi.aw_len = 8'd0;
        axi.ar_valid = 1'b1; axi.ar_addr = 32'h4000_0024; axi.ar_id = 6'd2;
        axi.ar_len = 8'd0;
        #1;
        chk("co_aw_ready", axi.aw_ready, 1);
        chk("co_ar_ready", axi.ar_ready, 0);
        tick();
        axi.aw_valid = 1'b0;
        #1;
        chk("co_wdata_ar_ready", axi.ar_ready, 0);
        axi.w_valid = 1'b1; axi.w_data = 32'hCAFE_F00D;
        tick();
        axi.w_valid = 1'b0;
        chk("co_setup_pwrite", apb.pwrite, 1);
        tick();
        tick();
        chk("co_b_valid", axi.b_valid, 1);
        chk("co_b_resp", axi.b_resp, 2'b00);
        chk("co_b_id", axi.b_id, 1);
        chk("co_b_ar_ready", axi.ar_ready, 0);
        axi.b_ready = 1'b1;
        tick();
        axi.b_ready = 1'b0;
        chk("co_idle_ar_ready", axi.ar_ready, 1);
        tick();
        axi.ar_valid = 1'b0;
        chk("co_rd_pwrite", apb.pwrite, 0);
        chk("co_rd_paddr", apb.paddr, 32'h4000_0024);
        apb.prdata = 32'h55AA_55AA;
        tick();
        tick();
        chk("co_r_valid", axi.r_valid, 1);
        chk("co_r_data", axi.r_data, 32'h55AA_55AA);
        chk("co_r_id", axi.r_id, 2);
        axi.r_ready = 1'b1;
        tick();
        axi.r_ready = 1'b0;

        // ---- reset during ACCESS, then a fresh read ----
        apb.pready = 1'b0;
        axi.aw_valid = 1'b1; axi.aw_addr = 32'h4000_0030; axi.aw_id = 6'd4;
        axi.aw_len = 8'd0;
        tick();
        axi.aw_valid = 1'b0;
        axi.w_valid = 1'b1; axi.w_data = 32'h7777_7777;
        tick();
        axi.w_valid = 1'b0;
        tick();
        chk("rs_access_penable", apb.penable, 1);
        rst_ni = 1'b0;
        tick();
        chk("rs_psel", apb.psel, 0);
        chk("rs_penable", apb.penable, 0);
        chk("rs_paddr", apb.paddr, 0);
        chk("rs_pwdata", apb.pwdata, 0);
        chk("rs_b_valid", axi.b_valid, 0);
        rst_ni = 1'b1;
        apb.pready = 1'b1;
        tick();
        tick();
        chk("rs_no_b", axi.b_valid, 0);
        axi.ar_valid = 1'b1; axi.ar_addr = 32'h4000_0008; axi.ar_id = 6'd6;
        axi.ar_len = 8'd0;
        #1;
        chk("rs_ar_ready", axi.ar_ready, 1);
        tick();
        axi.ar_valid = 1'b0;
        chk("rs_rd_paddr", apb.paddr, 32'h4000_0008);
        apb.prdata = 32'h0BAD_CAFE;
        tick();
        tick();
        chk("rs_r_valid", axi.r_valid, 1);
        chk("rs_r_data", axi.r_data, 32'h0BAD_CAFE);
        chk("rs_r_resp", axi.r_resp, 2'b00);
        chk("rs_r_last", axi.r_last, 1);
        chk("rs_r_id", axi.r_id, 6);
        axi.r_ready = 1'b1;
        tick();
        axi.r_ready = 1'b0;
        chk("rs_r_done", axi.r_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
